// File: rtl/subsurf_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// subsurf_seq : stage sequencer and shared RAM-port arbiter for subdivision
// Rev 1.0     : initial release
// ============================================================================
module subsurf_seq #(
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_STAGES  = 3,
  parameter int NUM_RAMS    = 3,
  parameter int START_PULSE = 2,
  parameter int LVL_WIDTH   = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [LVL_WIDTH-1:0]                   levels,
  input  logic [NUM_STAGES-1:0]                  stage_busy,
  output logic [NUM_STAGES-1:0]                  stage_start,
  input  logic [NUM_STAGES*NUM_RAMS-1:0]         st_en,
  input  logic [NUM_STAGES*NUM_RAMS*ADDR_WIDTH-1:0] st_a,
  input  logic [NUM_STAGES*NUM_RAMS*4-1:0]       st_we,
  input  logic [NUM_STAGES*NUM_RAMS*32-1:0]      st_di,
  output logic [NUM_RAMS-1:0]                    en,
  output logic [NUM_RAMS*ADDR_WIDTH-1:0]         a,
  output logic [NUM_RAMS*4-1:0]                  we,
  output logic [NUM_RAMS*32-1:0]                 di,
  output logic [$clog2(NUM_STAGES)-1:0]          stage_sel,
  output logic [LVL_WIDTH-1:0]                   level_cnt,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   aborted
);

  localparam int c_sel_w = $clog2(NUM_STAGES);
  localparam int c_pc_w  = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
  localparam logic [c_pc_w-1:0]  c_pulse_last = c_pc_w'(START_PULSE - 1);
  localparam logic [c_sel_w-1:0] c_last_stage = c_sel_w'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_sel_w-1:0]   r_stage_sel, w_sel_nxt;
  logic [LVL_WIDTH-1:0] r_level_cnt, w_lvl_nxt;
  logic [LVL_WIDTH-1:0] r_levels, w_levels_nxt;
  logic [c_pc_w-1:0]    r_pulse_cnt, w_pcnt_nxt;
  logic                 r_aborted, w_abort_hit;
  logic                 w_active;
  logic                 w_sel_busy;
  logic [LVL_WIDTH:0]   w_lvl_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stage_sel <= '0;
      r_level_cnt <= '0;
      r_levels    <= '0;
      r_pulse_cnt <= '0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stage_sel <= w_sel_nxt;
      r_level_cnt <= w_lvl_nxt;
      r_levels    <= w_levels_nxt;
      r_pulse_cnt <= w_pcnt_nxt;
      r_aborted   <= w_abort_hit;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_stage_sel;
    w_lvl_nxt    = r_level_cnt;
    w_levels_nxt = r_levels;
    w_pcnt_nxt   = r_pulse_cnt;
    w_abort_hit  = 1'b0;
    w_active     = (r_state == S_LAUNCH) || (r_state == S_WAIT);
    w_sel_busy   = 1'b0;
    stage_start  = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (r_stage_sel == c_sel_w'(s)) begin
        w_sel_busy     = stage_busy[s];
        stage_start[s] = (r_state == S_LAUNCH);
      end
    end
    // Widened so the level comparison cannot wrap at the top of the range.
    w_lvl_inc = {1'b0, r_level_cnt} + (LVL_WIDTH + 1)'(1);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (levels == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_levels_nxt = levels;
            w_sel_nxt    = '0;
            w_lvl_nxt    = '0;
            w_pcnt_nxt   = '0;
            w_state_nxt  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          w_abort_hit = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_pulse_cnt == c_pulse_last) begin
          w_pcnt_nxt  = '0;
          w_state_nxt = S_WAIT;
        end else begin
          w_pcnt_nxt = r_pulse_cnt + c_pc_w'(1);
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_abort_hit = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!w_sel_busy) begin
          w_pcnt_nxt = '0;
          if (r_stage_sel != c_last_stage) begin
            w_sel_nxt   = r_stage_sel + c_sel_w'(1);
            w_state_nxt = S_LAUNCH;
          end else if (w_lvl_inc < {1'b0, r_levels}) begin
            w_lvl_nxt   = w_lvl_inc[LVL_WIDTH-1:0];
            w_sel_nxt   = '0;
            w_state_nxt = S_LAUNCH;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Zero-latency RAM bus mux; everything is held at zero outside an active run.
  always_comb begin
    en = '0;
    a  = '0;
    we = '0;
    di = '0;
    if (w_active) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (r_stage_sel == c_sel_w'(s)) begin
          en = st_en[s*NUM_RAMS +: NUM_RAMS];
          a  = st_a[s*NUM_RAMS*ADDR_WIDTH +: NUM_RAMS*ADDR_WIDTH];
          we = st_we[s*NUM_RAMS*4 +: NUM_RAMS*4];
          di = st_di[s*NUM_RAMS*32 +: NUM_RAMS*32];
        end
      end
    end
  end

  assign stage_sel = r_stage_sel;
  assign level_cnt = r_level_cnt;
  assign busy      = w_active;
  assign done      = (r_state == S_DONE);
  assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: doc/subsurf_seq.md
Name: subsurf_seq

Overview:
- Parametrised stage sequencer and RAM-port arbiter for the subdivision pipeline (subdivide -> neighbour build -> average).
- Launches NUM_STAGES engines in order with a fixed-width start pulse and waits for each engine's busy to fall.
- Muxes the active engine's RAM buses onto the shared RAM ports.
- Repeats the whole stage sequence for a programmable number of subdivision levels. Supports abort.

Parameters:
- ADDR_WIDTH, 9, RAM address width.
- NUM_STAGES, 3, number of engines sequenced; stage 0 runs first.
- NUM_RAMS, 3, number of shared RAM ports.
- START_PULSE, 2, cycles stage_start is held high; must be >= 1.
- LVL_WIDTH, 3, width of levels and level_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the run; takes effect on the next edge.
- levels  in  LVL_WIDTH  number of full passes; sampled with start.
- stage_busy  in  NUM_STAGES  busy from each engine.
- stage_start  out  NUM_STAGES  one-hot start pulse to the engines.
- st_en  in  NUM_STAGES*NUM_RAMS  per-stage RAM enables; stage s, RAM r at bit s*NUM_RAMS+r.
- st_a  in  NUM_STAGES*NUM_RAMS*ADDR_WIDTH  per-stage addresses, same packing.
- st_we  in  NUM_STAGES*NUM_RAMS*4  per-stage byte write enables.
- st_di  in  NUM_STAGES*NUM_RAMS*32  per-stage write data.
- en  out  NUM_RAMS  RAM enables.
- a  out  NUM_RAMS*ADDR_WIDTH  RAM addresses.
- we  out  NUM_RAMS*4  RAM byte write enables.
- di  out  NUM_RAMS*32  RAM write data.
- stage_sel  out  $clog2(NUM_STAGES)  active stage index.
- level_cnt  out  LVL_WIDTH  current pass index, 0-based.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.

Behaviour:
- Reset: state=IDLE.
  - stage_start=0, stage_sel=0, level_cnt=0.
  - busy=0, done=0, aborted=0.
- Reset mid-run behaves identically.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - Combinational RAM outputs en, a, we, di are forced to 0.
  - Forcing to 0 also applies whenever state is IDLE or DONE.
- IDLE, start=1 at edge T:
  - levels==0: go to DONE. At T+1, done=1, busy=0, and no stage is launched.
  - Otherwise: latch levels, stage_sel=0, level_cnt=0, state=LAUNCH.
  - At T+1, busy=1 and stage_start[0]=1.
- LAUNCH:
  - stage_start[stage_sel]=1 for exactly START_PULSE cycles, counted by an internal counter. All other bits are 0.
  - Then stage_start=0 and state=WAIT.
- WAIT:
  - Holds while stage_busy[stage_sel]=1.
  - On the first cycle stage_busy[stage_sel]=0:
    - If stage_sel<NUM_STAGES-1: stage_sel+1, go to LAUNCH.
    - Else if level_cnt+1<levels: level_cnt+1, stage_sel=0, go to LAUNCH.
    - Else: go to DONE.
  - Engines must raise busy within START_PULSE cycles of start; the sequencer does not wait for a rising edge.
- DONE: one cycle with done=1 and busy=0, then IDLE. level_cnt and stage_sel hold their final values until the next start.
- While busy:
  - en/a/we/di = the stage_sel slice of st_*, passed combinationally with zero latency.
  - Slices of non-selected stages are ignored.
- abort=1 in LAUNCH or WAIT:
  - Next edge: stage_start=0, busy=0, aborted=1 for one cycle, state=IDLE.
  - RAM outputs are zeroed the same cycle.
  - abort in IDLE or DONE is ignored.
  - abort beats a simultaneous stage_busy fall.
- start while busy: ignored; no restart and no re-latch of levels.
- start and abort together in IDLE: start wins.
- The sequencer uses no internal RAM and counts no data; width rules are slice selection only.

Test Plan:
- Defaults, levels=1; model engines drop busy 5 cycles after start:
  - stage_start bits 0,1,2 each high for 2 cycles, in order.
  - done pulses once; busy high from start+1 until the done cycle.
  - level_cnt=0 throughout.
- levels=3, NUM_STAGES=3 -> 9 launches total, level_cnt visits 0,1,2, and there is a single done pulse.
- Mux check:
  - Stage 1 drives st_a slice=0x1A5 and we=4'hF on RAM 2; the other stages drive 0x0F0.
  - a[RAM2]=0x1A5 only while stage_sel=1.
  - All RAM outputs are 0 in IDLE and DONE.
- levels=0 with start -> done=1 at T+1, and stage_start never asserts.
- abort during stage 1 WAIT -> next cycle: aborted=1, busy=0, stage_start=0, RAM outputs 0, done never asserts.
- rst asserted in WAIT and start re-pulsed mid-run:
  - rst forces all outputs to reset values next cycle.
  - A start during a run has no effect on the sequence.
